// File: rtl/anubis_pkg.sv
// Shared definitions for the Anubis S-box scheduler: default job size,
// scheduler state encoding and requester (owner) encodings.
package anubis_pkg;

    // Bytes substituted per job (128-bit vector).
    localparam int NBYTES_DEFAULT = 16;

    // Scheduler state: waiting for a request, or streaming bytes through the S-box.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Requester encodings used for owner and last-grant tracking.
    localparam logic OWN_D = 1'b0;
    localparam logic OWN_K = 1'b1;

endpackage

// File: rtl/Sbox.sv
// Combinational Anubis S-box (8-bit involution): o_out = S[i_in], S[S[x]] = x.
module Sbox (
    input  logic [7:0] i_in,
    output logic [7:0] o_out
);

    localparam logic [7:0] TBL [256] = '{
        8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
        8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4, 8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
        8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
        8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b, 8'h5e, 8'hab, 8'h7f, 8'h78,
        8'h7c, 8'h2c, 8'h57, 8'hd2, 8'hdc, 8'h6d, 8'h7e, 8'h0d, 8'h53, 8'h94, 8'hc3, 8'h28, 8'h27, 8'h06, 8'h5f, 8'had,
        8'h67, 8'h5c, 8'h55, 8'h48, 8'h0e, 8'h52, 8'hea, 8'h42, 8'h5b, 8'h5d, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3c, 8'h4e,
        8'h38, 8'h8a, 8'h72, 8'h14, 8'he7, 8'hc6, 8'hde, 8'h50, 8'h8e, 8'h92, 8'hd1, 8'h77, 8'h93, 8'h45, 8'h9a, 8'hce,
        8'h2d, 8'h03, 8'h62, 8'hb6, 8'hb9, 8'hbf, 8'h96, 8'h6b, 8'h3f, 8'h07, 8'h12, 8'hae, 8'h40, 8'h34, 8'h46, 8'h3e,
        8'hdb, 8'hcf, 8'hec, 8'hcc, 8'hc1, 8'ha1, 8'hc0, 8'hd6, 8'h1d, 8'hf4, 8'h61, 8'h3b, 8'h10, 8'hd8, 8'h68, 8'ha0,
        8'hb1, 8'h0a, 8'h69, 8'h6c, 8'h49, 8'hfa, 8'h76, 8'hc4, 8'h9e, 8'h9b, 8'h6e, 8'h99, 8'hc2, 8'hb7, 8'h98, 8'hbc,
        8'h8f, 8'h85, 8'h1f, 8'hb4, 8'hf8, 8'h11, 8'h2e, 8'h00, 8'h25, 8'h1c, 8'h2a, 8'h3d, 8'h05, 8'h4f, 8'h7b, 8'hb2,
        8'h32, 8'h90, 8'haf, 8'h19, 8'ha3, 8'hf7, 8'h73, 8'h9d, 8'h15, 8'h74, 8'hee, 8'hca, 8'h9f, 8'h0f, 8'h1b, 8'h75,
        8'h86, 8'h84, 8'h9c, 8'h4a, 8'h97, 8'h1a, 8'h65, 8'hf6, 8'hed, 8'h09, 8'hbb, 8'h26, 8'h83, 8'heb, 8'h6f, 8'h81,
        8'h04, 8'h6a, 8'h43, 8'h01, 8'h17, 8'he1, 8'h87, 8'hf5, 8'h8d, 8'he3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
        8'hfe, 8'hd5, 8'h31, 8'hd9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hf2, 8'hf1, 8'h56, 8'hcd, 8'h82, 8'hc8, 8'hba, 8'hf0,
        8'hef, 8'he9, 8'he8, 8'hfd, 8'h89, 8'hd7, 8'hc7, 8'hb5, 8'ha4, 8'h2f, 8'h95, 8'h13, 8'h0b, 8'hf3, 8'he0, 8'h37
    };

    // Pure table lookup.
    always_comb begin
        o_out = TBL[i_in];
    end

endmodule

// File: rtl/anubis_sbox_sched.sv
// Time-multiplexed scheduler sharing one Anubis S-box between the round
// datapath (D) and the key schedule (K). One byte is substituted per clock;
// a job of NBYTES bytes takes NBYTES cycles after its accept edge.
//
// Handshake: req_x is a level. In IDLE, the scheduler accepts on the first
// edge with any req high (ties go to the requester not granted last time),
// samples vec_in_x on that edge only, and pulses ack_x for one cycle. The
// requester must drop req_x within NBYTES cycles of ack_x, otherwise it is
// taken as a new job. done_x pulses for one cycle when out_x is updated;
// out of the other requester is never touched. The FSM state is visible
// on busy (high exactly while in RUN).
module anubis_sbox_sched
    import anubis_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT,
    parameter int CW     = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_d,
    input  logic [8*NBYTES-1:0] vec_in_d,
    output logic                ack_d,
    output logic                done_d,
    output logic [8*NBYTES-1:0] out_d,
    input  logic                req_k,
    input  logic [8*NBYTES-1:0] vec_in_k,
    output logic                ack_k,
    output logic                done_k,
    output logic [8*NBYTES-1:0] out_k,
    output logic                busy,
    output logic                owner
);

    localparam int            W    = 8 * NBYTES;
    localparam logic [CW-1:0] LAST = CW'(NBYTES - 1);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_work;
    logic [W-1:0]  r_result;
    logic          r_last_grant;

    logic          w_any_req;
    logic          w_grant;
    logic [7:0]    w_sbox_out;
    logic [W-1:0]  w_result_next;

    // The single shared S-box always looks at the low byte of the work register.
    Sbox u_sbox (
        .i_in  (r_work[7:0]),
        .o_out (w_sbox_out)
    );

    // Arbitration and next result: a tie alternates away from the last grant;
    // each substituted byte enters at the top so byte i ends at byte i.
    always_comb begin
        w_any_req     = req_d | req_k;
        w_grant       = (req_d & req_k) ? ~r_last_grant : (req_k ? OWN_K : OWN_D);
        w_result_next = {w_sbox_out, r_result[W-1:8]};
    end

    // Scheduler FSM, byte shifter and per-requester result/pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_work       <= '0;
            r_result     <= '0;
            r_last_grant <= OWN_K;
            owner        <= OWN_K;
            ack_d        <= 1'b0;
            ack_k        <= 1'b0;
            done_d       <= 1'b0;
            done_k       <= 1'b0;
            out_d        <= '0;
            out_k        <= '0;
            busy         <= 1'b0;
        end else begin
            ack_d  <= 1'b0;
            ack_k  <= 1'b0;
            done_d <= 1'b0;
            done_k <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_any_req) begin
                        r_work       <= (w_grant == OWN_K) ? vec_in_k : vec_in_d;
                        owner        <= w_grant;
                        r_last_grant <= w_grant;
                        r_cnt        <= '0;
                        if (w_grant == OWN_K) begin
                            ack_k <= 1'b1;
                        end else begin
                            ack_d <= 1'b1;
                        end
                        r_state <= RUN;
                        busy    <= 1'b1;
                    end
                end
                RUN: begin
                    r_result <= w_result_next;
                    r_work   <= r_work >> 8;
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        if (owner == OWN_K) begin
                            out_k  <= w_result_next;
                            done_k <= 1'b1;
                        end else begin
                            out_d  <= w_result_next;
                            done_d <= 1'b1;
                        end
                        r_state <= IDLE;
                        busy    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_anubis_sbox_sched.sv
// Self-checking bench for anubis_sbox_sched: directed cases plus randomized
// jobs, checked against a transaction-level model (table lookup per byte,
// alternating tie-break, fixed 16-cycle job latency).
module tb_anubis_sbox_sched;

    localparam int W = 128;

    localparam logic [7:0] SBOX_REF [256] = '{
        8'ha7, 8'hd3, 8'he6, 8'h71, 8'hd0, 8'hac, 8'h4d, 8'h79, 8'h3a, 8'hc9, 8'h91, 8'hfc, 8'h1e, 8'h47, 8'h54, 8'hbd,
        8'h8c, 8'ha5, 8'h7a, 8'hfb, 8'h63, 8'hb8, 8'hdd, 8'hd4, 8'he5, 8'hb3, 8'hc5, 8'hbe, 8'ha9, 8'h88, 8'h0c, 8'ha2,
        8'h39, 8'hdf, 8'h29, 8'hda, 8'h2b, 8'ha8, 8'hcb, 8'h4c, 8'h4b, 8'h22, 8'haa, 8'h24, 8'h41, 8'h70, 8'ha6, 8'hf9,
        8'h5a, 8'he2, 8'hb0, 8'h36, 8'h7d, 8'he4, 8'h33, 8'hff, 8'h60, 8'h20, 8'h08, 8'h8b, 8'h5e, 8'hab, 8'h7f, 8'h78,
        8'h7c, 8'h2c, 8'h57, 8'hd2, 8'hdc, 8'h6d, 8'h7e, 8'h0d, 8'h53, 8'h94, 8'hc3, 8'h28, 8'h27, 8'h06, 8'h5f, 8'had,
        8'h67, 8'h5c, 8'h55, 8'h48, 8'h0e, 8'h52, 8'hea, 8'h42, 8'h5b, 8'h5d, 8'h30, 8'h58, 8'h51, 8'h59, 8'h3c, 8'h4e,
        8'h38, 8'h8a, 8'h72, 8'h14, 8'he7, 8'hc6, 8'hde, 8'h50, 8'h8e, 8'h92, 8'hd1, 8'h77, 8'h93, 8'h45, 8'h9a, 8'hce,
        8'h2d, 8'h03, 8'h62, 8'hb6, 8'hb9, 8'hbf, 8'h96, 8'h6b, 8'h3f, 8'h07, 8'h12, 8'hae, 8'h40, 8'h34, 8'h46, 8'h3e,
        8'hdb, 8'hcf, 8'hec, 8'hcc, 8'hc1, 8'ha1, 8'hc0, 8'hd6, 8'h1d, 8'hf4, 8'h61, 8'h3b, 8'h10, 8'hd8, 8'h68, 8'ha0,
        8'hb1, 8'h0a, 8'h69, 8'h6c, 8'h49, 8'hfa, 8'h76, 8'hc4, 8'h9e, 8'h9b, 8'h6e, 8'h99, 8'hc2, 8'hb7, 8'h98, 8'hbc,
        8'h8f, 8'h85, 8'h1f, 8'hb4, 8'hf8, 8'h11, 8'h2e, 8'h00, 8'h25, 8'h1c, 8'h2a, 8'h3d, 8'h05, 8'h4f, 8'h7b, 8'hb2,
        8'h32, 8'h90, 8'haf, 8'h19, 8'ha3, 8'hf7, 8'h73, 8'h9d, 8'h15, 8'h74, 8'hee, 8'hca, 8'h9f, 8'h0f, 8'h1b, 8'h75,
        8'h86, 8'h84, 8'h9c, 8'h4a, 8'h97, 8'h1a, 8'h65, 8'hf6, 8'hed, 8'h09, 8'hbb, 8'h26, 8'h83, 8'heb, 8'h6f, 8'h81,
        8'h04, 8'h6a, 8'h43, 8'h01, 8'h17, 8'he1, 8'h87, 8'hf5, 8'h8d, 8'he3, 8'h23, 8'h80, 8'h44, 8'h16, 8'h66, 8'h21,
        8'hfe, 8'hd5, 8'h31, 8'hd9, 8'h35, 8'h18, 8'h02, 8'h64, 8'hf2, 8'hf1, 8'h56, 8'hcd, 8'h82, 8'hc8, 8'hba, 8'hf0,
        8'hef, 8'he9, 8'he8, 8'hfd, 8'h89, 8'hd7, 8'hc7, 8'hb5, 8'ha4, 8'h2f, 8'h95, 8'h13, 8'h0b, 8'hf3, 8'he0, 8'h37
    };

    // ---------------- clock / reset / DUT ----------------
    logic         clk = 1'b0;
    logic         rst_n;
    logic         req_d, req_k;
    logic [W-1:0] vec_in_d, vec_in_k;
    logic         ack_d, ack_k, done_d, done_k, busy, owner;
    logic [W-1:0] out_d, out_k;

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    anubis_sbox_sched dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_d    (req_d),
        .vec_in_d (vec_in_d),
        .ack_d    (ack_d),
        .done_d   (done_d),
        .out_d    (out_d),
        .req_k    (req_k),
        .vec_in_k (vec_in_k),
        .ack_k    (ack_k),
        .done_k   (done_k),
        .out_k    (out_k),
        .busy     (busy),
        .owner    (owner)
    );

    // ---------------- scoreboard / model ----------------
    int           n_checks = 0;
    int           n_pass   = 0;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] m_out_d, m_out_k;
    logic         m_last;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] sub_vec(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W / 8; i++) r[8*i +: 8] = SBOX_REF[v[8*i +: 8]];
        return r;
    endfunction

    function automatic logic [W-1:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    task automatic model_reset();
        m_out_d = '0;
        m_out_k = '0;
        m_last  = 1'b1;
        exp_q.delete();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ack_d"},  ack_d,  0);
        chk({tag, "_ack_k"},  ack_k,  0);
        chk({tag, "_done_d"}, done_d, 0);
        chk({tag, "_done_k"}, done_k, 0);
        chk({tag, "_out_d"},  out_d,  0);
        chk({tag, "_out_k"},  out_k,  0);
        chk({tag, "_busy"},   busy,   0);
        chk({tag, "_owner"},  owner,  1);
    endtask

    // Pulse exclusivity, checked every cycle outside reset.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            chk("ack_excl",  ack_d & ack_k,   0);
            chk("done_excl", done_d & done_k, 0);
            chk("ackdone_d", ack_d & done_d,  0);
            chk("ackdone_k", ack_k & done_k,  0);
        end
    end

    // ---------------- driver ----------------
    // Raise the requested reqs, then follow accepts and completions until
    // every raised request has been served, checking each cycle.
    task automatic serve(input logic want_d, input logic want_k,
                         input logic [W-1:0] vd, input logic [W-1:0] vk);
        logic        pend_d, pend_k, in_fl, cur_own, exp_grant, ok, had_done;
        int unsigned t_req, t_ack, t_done;
        @(negedge clk);
        req_d = want_d; req_k = want_k; vec_in_d = vd; vec_in_k = vk;
        pend_d = want_d; pend_k = want_k; in_fl = 0; had_done = 0; ok = 0;
        cur_own = 1'bx; t_req = cyc; t_ack = cyc; t_done = cyc;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (ack_d || ack_k) begin
                exp_grant = (pend_d && pend_k) ? ~m_last : pend_k;
                chk("grant", ack_k, exp_grant);
                chk("owner_at_ack", owner, exp_grant);
                if (had_done) chk("ack_gap", cyc - t_done, 1);
                else          chk("ack_lat", cyc - t_req, 1);
                cur_own = ack_k; m_last = ack_k; in_fl = 1; t_ack = cyc;
                exp_q.push_back(sub_vec(ack_k ? vk : vd));
                // vec_in must only be sampled at accept: scramble it afterwards.
                if (ack_k) begin req_k = 0; pend_k = 0; vec_in_k = rand128(); end
                else       begin req_d = 0; pend_d = 0; vec_in_d = rand128(); end
            end
            if (done_d || done_k) begin
                chk("done_owner", done_k, cur_own);
                chk("done_lat", cyc - t_ack, 16);
                if (exp_q.size() == 0) chk("done_spurious", 1, 0);
                else if (done_k)       m_out_k = exp_q.pop_front();
                else                   m_out_d = exp_q.pop_front();
                in_fl = 0; had_done = 1; t_done = cyc;
            end
            chk("busy", busy, in_fl);
            chk("out_d", out_d, m_out_d);
            chk("out_k", out_k, m_out_k);
            if (!pend_d && !pend_k && !in_fl) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("serve_timeout", 0, 1);
        req_d = 0; req_k = 0;
    endtask

    task automatic abort_test();
        logic [W-1:0] vk;
        logic         got;
        int unsigned  t_ack;
        vk = rand128();
        @(negedge clk);
        req_d = 1; vec_in_d = rand128();
        got = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (ack_d) begin got = 1; break; end
        end
        chk("abort_ack_d", got, 1);
        req_d = 0; req_k = 1; vec_in_k = vk;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("abort_no_done", done_d, 0);
        end
        #2 rst_n = 0;
        #1 chk_reset("abort_rst");
        model_reset();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("abort_hold_ack", ack_k, 0);
        end
        rst_n = 1;
        @(negedge clk);
        chk("abort_k_accept", ack_k, 1);
        chk("abort_k_owner", owner, 1);
        req_k = 0; vec_in_k = rand128(); t_ack = cyc; got = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("abort_done_d_quiet", done_d, 0);
            if (done_k) begin got = 1; break; end
        end
        chk("abort_done_k_seen", got, 1);
        chk("abort_done_lat", cyc - t_ack, 16);
        m_out_k = sub_vec(vk);
        chk("abort_out_k", out_k, m_out_k);
        chk("abort_out_d", out_d, 0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [1:0] pat;
        rst_n = 0; req_d = 0; req_k = 0; vec_in_d = '0; vec_in_k = '0;
        model_reset();
        repeat (2) @(negedge clk);
        chk_reset("rst0");
        rst_n = 1;

        // single D job on zero vector
        serve(1, 0, '0, '0);
        chk("t2_out_d", out_d, {16{8'ha7}});
        chk("t2_out_k", out_k, 0);

        // byte order on K
        serve(0, 1, '0, 128'h000102030405060708090a0b0c0d0e0f);
        chk("t3_out_k", out_k, 128'ha7d3e671d0ac4d793ac991fc1e4754bd);

        // asynchronous reset mid-simulation with non-zero outputs
        @(negedge clk);
        #2 rst_n = 0;
        #1 chk_reset("rst_mid");
        model_reset();
        @(negedge clk);
        rst_n = 1;

        // contention after reset: D first, then K; next tie goes to D again
        serve(1, 1, rand128(), rand128());
        serve(1, 1, rand128(), rand128());

        // involution and all-ones vector
        serve(1, 0, {16{8'ha7}}, '0);
        chk("t5_inv", out_d, 0);
        serve(1, 0, {16{8'hff}}, '0);
        chk("t5_ff", out_d, {16{8'h37}});

        abort_test();

        // randomized jobs: D only, K only, or both at once
        for (int n = 0; n < 24; n++) begin
            pat = 2'($urandom_range(0, 2));
            serve(pat != 2'd1, pat != 2'd0, rand128(), rand128());
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/anubis_sbox_sched.md
Name: anubis_sbox_sched

Overview:
- Time-multiplexed scheduler that shares one combinational Anubis S-box (module Sbox, 8-bit in/out) between two requesters: the round datapath (D, gamma layer) and the key schedule (K).
- Each accepted job substitutes all NBYTES bytes of a 128-bit vector, one byte per clock, and returns the result to the requester that owns the job.
- Sits between the round controller / key-schedule controller and the single shared Sbox instance.

Parameters:
- NBYTES, 16, bytes per job; vector width is 8*NBYTES.
- CW, 4, byte-counter width; must satisfy 2^CW >= NBYTES.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req_d  in  1  datapath job request (level)
- vec_in_d  in  8*NBYTES  datapath input vector
- ack_d  out  1  one-cycle pulse: datapath job accepted
- done_d  out  1  one-cycle pulse: out_d updated
- out_d  out  8*NBYTES  datapath result, held
- req_k  in  1  key-schedule job request (level)
- vec_in_k  in  8*NBYTES  key-schedule input vector
- ack_k  out  1  one-cycle pulse: key job accepted
- done_k  out  1  one-cycle pulse: out_k updated
- out_k  out  8*NBYTES  key-schedule result, held
- busy  out  1  high while a job is in flight
- owner  out  1  current/last grant: 0=D, 1=K

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, cnt=0, work/result regs=0.
  - ack_*=0, done_*=0, out_d=out_k=0, busy=0, owner=1.
  - last_grant=K, so D wins the first tie.
  - Reset mid-job discards the job: no done, both outputs cleared.
- States: IDLE, RUN.
- IDLE, on an edge with any req high:
  - Grant: if only one req is high, grant it. If both are high, grant the requester not equal to last_grant.
  - Latch the granted vec_in into the work register, set owner and last_grant.
  - cnt<=0, ack_<owner><=1 for one cycle, then go to RUN.
  - If no req is high, stay in IDLE.
- RUN, on each edge:
  - Sbox input = work[7:0]. The result is shifted into the result register from the top: result <= {sbox_out, result[8*NBYTES-1:8]}.
  - work shifts right by 8.
  - Byte i of the input (bits 8i+7:8i) therefore lands at byte i of the output.
  - cnt increments. When cnt==NBYTES-1, this edge processes the last byte, and:
    - out_<owner> <= the full result, including this byte
    - done_<owner> <= 1 for one cycle
    - state goes to IDLE
- Timing, with accept edge E0:
  - ack visible in the cycle after E0.
  - Bytes processed at edges E1..E16.
  - done visible in the cycle after E16, i.e. 16 cycles after ack.
  - Next accept can happen at E17; throughput is 17 cycles per job.
- busy = (state==RUN), registered.
- Requester rules:
  - A requester must drop req before the scheduler returns to IDLE; it has 16 cycles after ack.
  - A req still high in IDLE is treated as a new job.
  - vec_in is sampled only at the accept edge.
- Output ownership: out of the non-owning requester never changes during another requester's job.
- Fixed values: ack_* and done_* are never high in the same cycle for both requesters. ack and done for one requester are never simultaneous.

Decomposition:
- Package anubis_pkg:
  - NBYTES default
  - state enum {IDLE, RUN}
  - owner encodings OWN_D=0, OWN_K=1
- Sub-module: exactly one instance of the existing combinational Sbox, driven by work[7:0]. No other sub-modules.

Test Plan:
1. Reset: assert rst_n=0 mid-simulation → all outputs 0, owner=1, busy=0, in the same cycle (async).
2. req_d=1, vec_in_d=0 → ack_d pulse; busy high 16 cycles; done_d 16 cycles after ack_d; out_d={16{8'ha7}}; out_k stays 0.
3. Byte order: req_k=1, vec_in_k=128'h000102030405060708090a0b0c0d0e0f → out_k=128'ha7d3e671d0ac4d793ac991fc1e4754bd.
4. Contention: req_d and req_k both high after reset → D is accepted at E0 and K at E17; done_k appears 17 cycles after done_d; owner goes 0 then 1. The next tie grants D.
5. Involution: feed out_d={16{8'ha7}} back as vec_in_d → out_d=0. Feed vec_in_d={16{8'hff}} → {16{8'h37}}.
6. Abort: pulse rst_n low 8 cycles into a D job → no done_d, out_d=0; a pending req_k is accepted on the first edge after rst_n rises.
